// File: rtl/alu_chk_pkg.sv
// alu_chk_pkg: shared widths, FSM state type and FIFO entry fields for the ALU result checker
package alu_chk_pkg;
  localparam int STATUS_W = 4;
  localparam int CNT_W = 8;
  typedef enum logic {RUN, HALT} chk_state_e;
  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] mask;
  } exp_tag_t;
endpackage

// File: rtl/chk_fifo.sv
// chk_fifo: show-ahead FIFO with wrap-bit pointers
// Ports: clk_i/rst_ni clock and async active-low reset, clr_i sync flush,
//        push_i/data_i write side, pop_i/data_o read side (data_o is the head), full_o/empty_o occupancy.
module chk_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_i) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
  assign data_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  // same slot index but different lap bit means the writer is a full lap ahead
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: queues expected ALU responses and scores observed results against them
// Ports: i_clk/i_reset clock and async active-low reset; i_exp_* / o_exp_ready expectation push;
//        i_obs_* observation strobe; i_halt_en, i_clear controls;
//        o_match_cnt/o_mismatch_cnt saturating counters; o_error/o_underflow sticky flags; o_busy, o_halted status.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int M = 4,
  parameter int DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_exp_valid,
  output logic                o_exp_ready,
  input  logic [M-1:0]        i_exp_result,
  input  logic [STATUS_W-1:0] i_exp_status,
  input  logic [STATUS_W-1:0] i_exp_mask,
  input  logic                i_obs_valid,
  input  logic [M-1:0]        i_obs_result,
  input  logic [STATUS_W-1:0] i_obs_status,
  input  logic                i_halt_en,
  input  logic                i_clear,
  output logic [CNT_W-1:0]    o_match_cnt,
  output logic [CNT_W-1:0]    o_mismatch_cnt,
  output logic                o_error,
  output logic                o_underflow,
  output logic                o_busy,
  output logic                o_halted
);
  typedef struct packed {
    logic [M-1:0] result;
    exp_tag_t     tag;
  } entry_t;
  chk_state_e state_q, state_d;
  logic [CNT_W-1:0] match_q, match_d, mis_q, mis_d;
  logic err_q, err_d, uf_q, uf_d, live_q;
  logic full, empty, push, pop, obs, hit, bad, under;
  entry_t head, wr;
  assign wr = {i_exp_result, i_exp_status, i_exp_mask};
  chk_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i(i_clk),
    .rst_ni(i_reset),
    .clr_i(i_clear),
    .push_i(push),
    .pop_i(pop),
    .data_i(wr),
    .data_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  always_comb begin
    obs = i_obs_valid && state_q == RUN;
    pop = obs && !empty && !i_clear;
    push = i_exp_valid && o_exp_ready && !i_clear;
    hit = head.result == i_obs_result && ((i_obs_status ^ head.tag.status) & head.tag.mask) == '0;
    bad = pop && !hit;
    under = obs && empty;
    match_d = i_clear ? '0 : (pop && hit && match_q != '1) ? match_q + CNT_W'(1) : match_q;
    mis_d = i_clear ? '0 : (bad && mis_q != '1) ? mis_q + CNT_W'(1) : mis_q;
    err_d = !i_clear && (err_q || bad);
    uf_d = !i_clear && (uf_q || under);
    state_d = i_clear ? RUN : (state_q == RUN && i_halt_en && (bad || under)) ? HALT : state_q;
  end
  // live_q holds ready low until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      match_q <= '0;
      mis_q <= '0;
      err_q <= 1'b0;
      uf_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      mis_q <= mis_d;
      err_q <= err_d;
      uf_q <= uf_d;
      live_q <= 1'b1;
    end
  end
  assign o_exp_ready = live_q && state_q == RUN && !full;
  assign o_match_cnt = match_q;
  assign o_mismatch_cnt = mis_q;
  assign o_error = err_q;
  assign o_underflow = uf_q;
  assign o_busy = !empty;
  assign o_halted = state_q == HALT;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed and random stimulus scored against a queue-based reference model
module tb_alu_result_checker;
  localparam int M = 4;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 1, ev = 0, ov = 0, halt_en = 0, clr = 0;
  logic [M-1:0] er = 0, orr = 0;
  logic [3:0] es = 0, em = 0, os = 0;
  logic rdy, err, uf, busy, halted;
  logic [7:0] mc, mmc;
  typedef struct {int r; int s; int m;} ent_t;
  ent_t q[$];
  int m_match, m_mis, n_chk, n_pass;
  bit m_err, m_uf, m_halt, m_init;
  always #5 clk = ~clk;
  alu_result_checker #(.M(M), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_exp_valid(ev), .o_exp_ready(rdy),
    .i_exp_result(er), .i_exp_status(es), .i_exp_mask(em),
    .i_obs_valid(ov), .i_obs_result(orr), .i_obs_status(os),
    .i_halt_en(halt_en), .i_clear(clr),
    .o_match_cnt(mc), .o_mismatch_cnt(mmc), .o_error(err), .o_underflow(uf),
    .o_busy(busy), .o_halted(halted)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_reset();
    q.delete();
    m_match = 0; m_mis = 0; m_err = 0; m_uf = 0; m_halt = 0; m_init = 0;
  endtask
  task automatic model_step();
    bit ready, mis, under;
    ent_t h;
    ready = m_init && !m_halt && q.size() < DEPTH;
    m_init = 1;
    mis = 0; under = 0;
    if (clr) begin
      q.delete();
      m_match = 0; m_mis = 0; m_err = 0; m_uf = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (ov && q.size() == 0) under = 1;
      else if (ov) begin
        h = q.pop_front();
        if (h.r == int'(orr) && ((h.s ^ int'(os)) & h.m) == 0) m_match = m_match < 255 ? m_match + 1 : 255;
        else begin
          mis = 1;
          m_mis = m_mis < 255 ? m_mis + 1 : 255;
        end
      end
      if (ev && ready) q.push_back('{int'(er), int'(es), int'(em)});
      m_err |= mis;
      m_uf |= under;
      if (halt_en && (mis || under)) m_halt = 1;
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("match_cnt", mc, m_match);
    chk("mismatch_cnt", mmc, m_mis);
    chk("error", err, m_err);
    chk("underflow", uf, m_uf);
    chk("busy", busy, q.size() > 0);
    chk("halted", halted, m_halt);
    chk("exp_ready", rdy, m_init && !m_halt && q.size() < DEPTH);
  endtask
  task automatic push(input int r, input int s, input int m);
    ev = 1; er = M'(r); es = 4'(s); em = 4'(m);
    cyc();
    ev = 0;
  endtask
  task automatic obs(input int r, input int s);
    ov = 1; orr = M'(r); os = 4'(s);
    cyc();
    ov = 0;
  endtask
  initial begin
    model_reset();
    #1 rst_n = 0;
    #1;
    chk("rst_ready", rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", mc, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("ready_before_edge", rdy, 0);
    cyc();
    chk("ready_after_release", rdy, 1);
    push(1, 0, 15);
    obs(1, 0);
    chk("first_match", mc, 1);
    chk("first_busy", busy, 0);
    halt_en = 1;
    push(5, 0, 15);
    obs(4, 0);
    chk("halt_mismatch", mmc, 1);
    chk("halt_state", halted, 1);
    chk("halt_ready", rdy, 0);
    ev = 1; ov = 1;
    cyc();
    ev = 0; ov = 0;
    clr = 1;
    cyc();
    clr = 0;
    halt_en = 0;
    chk("clear_mismatch", mmc, 0);
    chk("clear_ready", rdy, 1);
    for (int i = 0; i < 4; i++) push(i + 2, 0, 15);
    chk("full_ready", rdy, 0);
    push(9, 0, 15);
    obs(2, 0);
    chk("pop_ready", rdy, 1);
    push(10, 0, 15);
    obs(3, 0); obs(4, 0); obs(5, 0); obs(10, 0);
    chk("wrap_order_mis", mmc, 0);
    chk("wrap_order_match", mc, 5);
    obs(7, 0);
    chk("underflow_flag", uf, 1);
    chk("underflow_cnt", mc, 5);
    clr = 1; cyc(); clr = 0;
    ev = 1; er = 6; es = 0; em = 15; ov = 1; orr = 6; os = 0;
    cyc();
    ev = 0; ov = 0;
    chk("uf_push_flag", uf, 1);
    chk("uf_push_busy", busy, 1);
    obs(6, 0);
    clr = 1; cyc(); clr = 0;
    push(3, 5, 14);
    obs(3, 4);
    chk("mask_match", mc, 1);
    for (int i = 0; i < 3; i++) push(i, i, 15);
    #3 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", rdy, 0);
    chk("midrst_match", mc, 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    cyc();
    push(1, 0, 0);
    ev = 1; er = 1; es = 0; em = 0; ov = 1; orr = 1; os = 0;
    repeat (265) cyc();
    ev = 0; ov = 0;
    chk("saturate", mc, 255);
    clr = 1; cyc(); clr = 0;
    for (int n = 0; n < 400; n++) begin
      ev = $urandom_range(0, 1) == 1;
      er = M'($urandom); es = 4'($urandom); em = 4'($urandom);
      ov = $urandom_range(0, 9) < 4;
      orr = M'($urandom); os = 4'($urandom);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        orr = M'(q[0].r);
        os = 4'(q[0].s) ^ (4'($urandom) & ~4'(q[0].m));
      end
      halt_en = $urandom_range(0, 9) == 0;
      clr = $urandom_range(0, 19) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter M, default 4: ALU result width in bits.
REQ-002 Parameter DEPTH, default 4: expectation FIFO depth; power of two, at least 2.
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_exp_valid  in  1  an expected-response entry is offered.
REQ-006 o_exp_ready  out  1  the checker can accept an expected-response entry.
REQ-007 i_exp_result  in  M  expected ALU result.
REQ-008 i_exp_status  in  4  expected ALU status.
REQ-009 i_exp_mask  in  4  per-bit status compare enable; 1 means the bit is compared.
REQ-010 i_obs_valid  in  1  strobe: the ALU output is sampled this cycle.
REQ-011 i_obs_result  in  M  observed ALU result.
REQ-012 i_obs_status  in  4  observed ALU status.
REQ-013 i_halt_en  in  1  when 1, a mismatch or underflow halts checking.
REQ-014 i_clear  in  1  synchronous flush of the FIFO, counters and sticky flags.
REQ-015 o_match_cnt  out  8  count of matching observations.
REQ-016 o_mismatch_cnt  out  8  count of mismatching observations.
REQ-017 o_error  out  1  sticky: at least one mismatch has occurred.
REQ-018 o_underflow  out  1  sticky: an observation arrived while the FIFO was empty.
REQ-019 o_busy  out  1  the FIFO holds at least one entry.
REQ-020 o_halted  out  1  the state machine is in HALT.

Function
REQ-021 State machine has two states, RUN and HALT; reset and i_clear both enter RUN.
REQ-022 Transition RUN->HALT occurs on a registered mismatch or underflow when i_halt_en=1; HALT is left only via i_clear or reset.
REQ-023 o_exp_ready = (state==RUN) and FIFO not full; ready does not depend on a same-cycle pop.
REQ-024 An entry is pushed when i_exp_valid and o_exp_ready are both 1; the entry is {result, status, mask}.
REQ-025 In RUN, i_obs_valid with a non-empty FIFO pops the head entry and compares it against the observation in the same cycle.
REQ-026 Match condition: (obs_result == exp_result) and ((obs_status ^ exp_status) & mask) == 0.
REQ-027 Compare latency is one cycle: counters and flags reflect the observation on the edge after the i_obs_valid cycle.
REQ-028 Counters saturate at 255 and never wrap.
REQ-029 i_obs_valid with an empty FIFO sets o_underflow, leaves counters unchanged, and has no bypass from a same-cycle push.
REQ-030 A simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged and preserves ordering.
REQ-031 In HALT, observations are ignored and pushes are refused; counters and flags hold.
REQ-032 i_clear has priority over a same-cycle push, pop or compare; the next cycle shows the reset values.
REQ-033 The FIFO read and write pointers wrap modulo DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-034 Asynchronous assertion (i_reset=0) immediately forces: state RUN, FIFO empty, counters 0, o_error 0, o_underflow 0, o_busy 0, o_halted 0, o_exp_ready 0.
REQ-035 o_exp_ready becomes 1 on the first rising edge after deassertion; reset mid-operation discards all pending entries and in-flight compares.

Structure
REQ-036 Package alu_chk_pkg holds the state enum (RUN, HALT), STATUS_W=4, CNT_W=8 and the FIFO entry struct typedef.
REQ-037 The FIFO is a sub-module named chk_fifo, parameterised by width and DEPTH, with push/pop/full/empty ports.

Verification
REQ-038 Reset then release -> all counters and flags 0; o_exp_ready=1 one edge after release.
REQ-039 Push exp {0001, 0000, mask 1111}; obs {0001, 0000} -> o_match_cnt=1 one cycle later, o_busy=0.
REQ-040 i_halt_en=1; push exp 0101; obs 0100 -> o_mismatch_cnt=1, o_error=1, o_halted=1, o_exp_ready=0; then i_clear -> all cleared, o_exp_ready=1.
REQ-041 Push 4 entries -> o_exp_ready=0 and a 5th push is refused; one pop -> ready=1 and the next push is accepted; FIFO order is checked across pointer wrap.
REQ-042 i_obs_valid with an empty FIFO -> o_underflow=1 and counters unchanged; the same case with a simultaneous push -> still underflow, and the entry remains queued.
REQ-043 Mask 1110 with status differing only in bit 0 -> counted as a match; asserting reset with 3 entries queued -> FIFO empty immediately.
